// File: rtl/phase_corr_pkg.sv
// phase_corr_pkg: shared definitions for the phase-correlation back end.
//   - default matrix side length and element width
//   - scan controller state enum
//   - elem_at(): extracts element k of a packed correlation surface
package phase_corr_pkg;

  localparam int DIM_DEF = 32;
  localparam int W_DEF   = 16;
  localparam int N_DEF   = DIM_DEF * DIM_DEF * W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Element k sits at bits [w*k + w-1 : w*k]. The result is W_DEF bits wide.
  // Callers narrower than W_DEF keep only the low w bits.
  function automatic logic [W_DEF-1:0] elem_at(input logic [N_DEF-1:0] mat,
                                                input int unsigned      k,
                                                input int unsigned      w);
    logic [N_DEF-1:0] shifted;
    shifted = mat >> (k * w);
    return shifted[W_DEF-1:0];
  endfunction

endpackage

// File: rtl/corr_shift_wrap.sv
// corr_shift_wrap: maps an unsigned matrix coordinate to a signed shift.
//   coord < DIM/2 -> coord, otherwise coord - DIM (two's complement, SW bits).
// Ports:
//   coord  in  SW  unsigned row or column index
//   shift  out SW  signed shift in -DIM/2 .. DIM/2-1
module corr_shift_wrap #(
  parameter int DIM = 32,
  parameter int SW  = $clog2(DIM)
) (
  input  logic        [SW-1:0] coord,
  output logic signed [SW-1:0] shift
);

  localparam logic [SW-1:0] HALF = SW'(DIM / 2);

  logic [SW:0] ext_s;

  // Wrap coordinates in the upper half of the matrix to negative shifts.
  always_comb begin
    ext_s = {1'b0, coord} - (SW + 1)'(DIM);
    if (coord < HALF) begin
      shift = coord;
    end else begin
      shift = ext_s[SW-1:0];
    end
  end

endmodule

// File: rtl/corr_peak_finder.sv
// corr_peak_finder: scans a captured correlation surface, one element per
// clock, and reports the maximum as a wrapped (dx, dy) motion vector.
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   capture corr_re and scan (accepted only when idle)
//   corr_re    in   N   packed signed surface, element k at [W*k+W-1 : W*k]
//   busy       out  1   high whenever not idle
//   out_valid  out  1   result available
//   out_ready  in   1   consumer accepts the result
//   dx, dy     out  SW  signed shifts derived from peak column / row
//   peak_val   out  W   signed peak amplitude
//   peak_idx   out  IW  linear index of the peak (row*DIM + col)
module corr_peak_finder
  import phase_corr_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int W   = W_DEF,
  parameter int N   = DIM * DIM * W,
  parameter int IW  = $clog2(DIM * DIM),
  parameter int SW  = $clog2(DIM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic        [N-1:0] corr_re,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [SW-1:0] dx,
  output logic signed [SW-1:0] dy,
  output logic signed [W-1:0] peak_val,
  output logic        [IW-1:0] peak_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DIM * DIM - 1);

  state_e                state_q, state_d;
  logic        [N-1:0]   corr_q, corr_d;
  logic        [IW-1:0]  idx_q, idx_d;
  logic signed [W-1:0]   max_q, max_d;
  logic        [IW-1:0]  max_idx_q, max_idx_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [SW-1:0]  dx_q, dx_d;
  logic signed [SW-1:0]  dy_q, dy_d;
  logic signed [W-1:0]   peak_val_q, peak_val_d;
  logic        [IW-1:0]  peak_idx_q, peak_idx_d;

  logic        [W_DEF-1:0] elem_raw_s;
  logic signed [W-1:0]     elem_s;
  logic signed [W-1:0]     cand_max_s;
  logic        [IW-1:0]    cand_idx_s;
  logic signed [SW-1:0]    dx_s;
  logic signed [SW-1:0]    dy_s;

  // Select the current element and fold it into the running maximum.
  // Element 0 always seeds the maximum so all-negative surfaces work;
  // afterwards only a strictly larger value replaces it (lowest index wins ties).
  always_comb begin
    elem_raw_s = elem_at(N_DEF'(corr_q), 32'(idx_q), 32'(W));
    elem_s     = elem_raw_s[W-1:0];
    if ((idx_q == '0) || (elem_s > max_q)) begin
      cand_max_s = elem_s;
      cand_idx_s = idx_q;
    end else begin
      cand_max_s = max_q;
      cand_idx_s = max_idx_q;
    end
  end

  corr_shift_wrap #(.DIM(DIM), .SW(SW)) u_wrap_col (
    .coord (cand_idx_s[SW-1:0]),
    .shift (dx_s)
  );

  corr_shift_wrap #(.DIM(DIM), .SW(SW)) u_wrap_row (
    .coord (cand_idx_s[IW-1:SW]),
    .shift (dy_s)
  );

  // Next-state logic for the IDLE -> SCAN -> OUT controller and its datapath.
  always_comb begin
    state_d     = state_q;
    corr_d      = corr_q;
    idx_d       = idx_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    out_valid_d = out_valid_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    peak_val_d  = peak_val_q;
    peak_idx_d  = peak_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          corr_d  = corr_re;
          idx_d   = '0;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        max_d     = cand_max_s;
        max_idx_d = cand_idx_s;
        if (idx_q == LAST_IDX) begin
          // Final element: publish the result from the combinational candidate.
          out_valid_d = 1'b1;
          dx_d        = dx_s;
          dy_d        = dy_s;
          peak_val_d  = cand_max_s;
          peak_idx_d  = cand_idx_s;
          idx_d       = '0;
          state_d     = ST_OUT;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    // busy is registered, so it is derived from where the FSM is heading.
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      corr_q      <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      peak_val_q  <= '0;
      peak_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      corr_q      <= corr_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      peak_val_q  <= peak_val_d;
      peak_idx_q  <= peak_idx_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign peak_val  = peak_val_q;
  assign peak_idx  = peak_idx_q;

endmodule

// File: tb/tb_corr_peak_finder.sv
// Self-checking bench for corr_peak_finder (DIM = 32, W = 16).
module tb_corr_peak_finder;

  localparam int DIM = 32;
  localparam int W   = 16;
  localparam int NE  = DIM * DIM;
  localparam int N   = NE * W;
  localparam int IW  = $clog2(NE);
  localparam int SW  = $clog2(DIM);

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [N-1:0]         corr_re;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [SW-1:0] dx;
  logic signed [SW-1:0] dy;
  logic signed [W-1:0]  peak_val;
  logic [IW-1:0]        peak_idx;

  corr_peak_finder #(.DIM(DIM), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .corr_re   (corr_re),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx        (dx),
    .dy        (dy),
    .peak_val  (peak_val),
    .peak_idx  (peak_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int mat [NE];
  int exp_idx, exp_val, exp_dx, exp_dy;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int k = 0; k < NE; k++) begin
      logic [31:0] v;
      v = mat[k];
      corr_re[k*W +: W] = v[W-1:0];
    end
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < NE; k++) mat[k] = v;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int k = 0; k < NE; k++) mat[k] = lo + int'($urandom_range(hi - lo, 0));
  endtask

  // Reference: first strictly-largest element, then wrap row/col to shifts.
  task automatic model();
    int best, r, c;
    best = 0;
    for (int k = 1; k < NE; k++) if (mat[k] > mat[best]) best = k;
    r = best / DIM;
    c = best % DIM;
    exp_idx = best;
    exp_val = mat[best];
    exp_dx  = (c < DIM / 2) ? c : c - DIM;
    exp_dy  = (r < DIM / 2) ? r : r - DIM;
  endtask

  task automatic check_result(input string tag);
    check({tag, ".peak_idx"}, 32'(peak_idx), exp_idx);
    check({tag, ".peak_val"}, 32'(peak_val), exp_val);
    check({tag, ".dx"},       32'(dx),       exp_dx);
    check({tag, ".dy"},       32'(dy),       exp_dy);
  endtask

  // Pulse start for one edge (E0), then count edges until out_valid rises.
  task automatic run_scan(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      tick();
      lat++;
    end
  endtask

  task automatic scan_and_check(input string tag);
    int lat;
    model();
    pack();
    run_scan(lat);
    check({tag, ".latency"}, lat, NE);
    check({tag, ".out_valid"}, 32'(out_valid), 1);
    check_result(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 0);
    check({tag, ".busy_idle"}, 32'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sv_dx, sv_dy, sv_val, sv_idx;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    corr_re   = '0;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    check("rst.busy", 32'(busy), 0);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.dx", 32'(dx), 0);
    check("rst.dy", 32'(dy), 0);
    check("rst.peak_val", 32'(peak_val), 0);
    check("rst.peak_idx", 32'(peak_idx), 0);

    // Single peak at row 3, col 5; also check busy right after E0
    fill(0);
    mat[3*32+5] = 1000;
    pack();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("single.busy_after_start", 32'(busy), 1);
    lat = 1;
    while (!out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    lat = lat - 1;
    check("single.latency", lat, NE);
    check("single.peak_idx_const", 32'(peak_idx), 101);
    check("single.dx_const", 32'(dx), 5);
    check("single.dy_const", 32'(dy), 3);
    check("single.peak_val_const", 32'(peak_val), 1000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single.valid_drop", 32'(out_valid), 0);
    check("single.busy_idle", 32'(busy), 0);

    // Wrap-around peak at row 31, col 16
    fill(0);
    mat[1008] = 500;
    scan_and_check("wrap");

    // Ties and negatives
    fill(-7);
    mat[40]  = -2;
    mat[900] = -2;
    scan_and_check("ties");
    fill(-300);
    scan_and_check("allneg");

    // Random surfaces: full range, and narrow range to force ties
    for (int t = 0; t < 3; t++) begin
      fill_random(-32768, 32767);
      scan_and_check("rand_full");
    end
    fill_random(-3, 3);
    scan_and_check("rand_ties");

    // out_ready already high before the result appears
    fill_random(-1000, 1000);
    model();
    pack();
    out_ready = 1'b1;
    run_scan(lat);
    check("early_ready.latency", lat, NE);
    check_result("early_ready");
    tick();
    out_ready = 1'b0;
    check("early_ready.valid_drop", 32'(out_valid), 0);

    // Backpressure, input change and start pulse during the scan
    fill_random(-20000, 20000);
    model();
    pack();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    fill(-5);
    mat[7] = 32767;
    pack();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    check("bp.latency", lat + 101, NE);
    check_result("bp");
    sv_dx  = 32'(dx);
    sv_dy  = 32'(dy);
    sv_val = 32'(peak_val);
    sv_idx = 32'(peak_idx);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp.hold_valid", 32'(out_valid), 1);
      check("bp.hold_idx", 32'(peak_idx), exp_idx);
      check("bp.hold_val", 32'(peak_val), exp_val);
      check("bp.hold_dx", 32'(dx), exp_dx);
      check("bp.hold_dy", 32'(dy), exp_dy);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("bp.valid_drop", 32'(out_valid), 0);
    check("bp.busy_idle", 32'(busy), 0);
    tick();
    check("bp.start_in_handshake_ignored", 32'(busy), 0);
    check("bp.retain_dx", 32'(dx), sv_dx);
    check("bp.retain_dy", 32'(dy), sv_dy);
    check("bp.retain_val", 32'(peak_val), sv_val);
    check("bp.retain_idx", 32'(peak_idx), sv_idx);

    // Reset in the middle of a scan
    fill_random(-500, 500);
    pack();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (500) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.busy", 32'(busy), 0);
    check("midrst.out_valid", 32'(out_valid), 0);
    check("midrst.dx", 32'(dx), 0);
    check("midrst.dy", 32'(dy), 0);
    check("midrst.peak_val", 32'(peak_val), 0);
    check("midrst.peak_idx", 32'(peak_idx), 0);
    repeat (3) tick();
    check("midrst.no_result", 32'(out_valid), 0);
    fill_random(-500, 500);
    scan_and_check("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
